// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : RV32I/RV64I integer execute stage with valid/ready handshakes and
//            an iterative multi-cycle shifter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [10:0]     funct_code,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      alu_op,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [6:0] c_opc_r = 7'b0110011;
    localparam logic [6:0] c_opc_i = 7'b0010011;

    localparam logic [4:0] c_add  = 5'd1,  c_addi  = 5'd2,  c_or   = 5'd3;
    localparam logic [4:0] c_ori  = 5'd4,  c_xor   = 5'd5,  c_xori = 5'd6;
    localparam logic [4:0] c_and  = 5'd7,  c_andi  = 5'd8,  c_sub  = 5'd9;
    localparam logic [4:0] c_slt  = 5'd10, c_slti  = 5'd11, c_sltu = 5'd12;
    localparam logic [4:0] c_sltiu = 5'd13, c_slli = 5'd14, c_srli = 5'd15;
    localparam logic [4:0] c_srai = 5'd16, c_sll   = 5'd17, c_srl  = 5'd18;
    localparam logic [4:0] c_sra  = 5'd19;

    localparam logic [SHW:0] c_step = (SHW+1)'(SHIFT_STEP);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    logic [0:0]      r_state, w_state_nxt;
    logic [XLEN-1:0] r_acc;
    logic [SHW:0]    r_rem;
    logic            r_sh_left, r_sh_arith;
    logic [4:0]      r_sh_op;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_alu_op;
    logic            r_illegal;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic            w_f7b5;
    logic [4:0]      w_op;
    logic            w_illegal;
    logic [XLEN-1:0] w_b;
    logic [SHW-1:0]  w_shamt;
    logic            w_is_shl, w_is_shr, w_is_arith, w_start_shift;
    logic [XLEN-1:0] w_alu_res;
    logic            w_accept, w_in_ready;
    logic [SHW:0]    w_step, w_rem_nxt;
    logic [XLEN-1:0] w_acc_sra, w_acc_nxt;

    assign w_opcode = funct_code[6:0];
    assign w_f3     = funct_code[9:7];
    assign w_f7b5   = funct_code[10];

    always_comb begin
        w_op = 5'd0;
        if (w_opcode == c_opc_r) begin
            case ({w_f7b5, w_f3})
                4'b0000: w_op = c_add;
                4'b0110: w_op = c_or;
                4'b0100: w_op = c_xor;
                4'b0111: w_op = c_and;
                4'b1000: w_op = c_sub;
                4'b0010: w_op = c_slt;
                4'b0011: w_op = c_sltu;
                4'b0001: w_op = c_sll;
                4'b0101: w_op = c_srl;
                4'b1101: w_op = c_sra;
                default: w_op = 5'd0;
            endcase
        end else if (w_opcode == c_opc_i) begin
            case (w_f3)
                3'b000: w_op = c_addi;
                3'b110: w_op = c_ori;
                3'b100: w_op = c_xori;
                3'b111: w_op = c_andi;
                3'b010: w_op = c_slti;
                3'b011: w_op = c_sltiu;
                3'b001: w_op = w_f7b5 ? 5'd0 : c_slli;
                default: w_op = w_f7b5 ? c_srai : c_srli;
            endcase
        end
    end

    assign w_illegal  = (w_op == 5'd0);
    assign w_b        = (w_opcode == c_opc_r) ? rs2_data : imm;
    assign w_shamt    = w_b[SHW-1:0];
    assign w_is_shl   = (w_op == c_sll) || (w_op == c_slli);
    assign w_is_arith = (w_op == c_sra) || (w_op == c_srai);
    assign w_is_shr   = w_is_arith || (w_op == c_srl) || (w_op == c_srli);
    assign w_start_shift = (w_is_shl || w_is_shr) && (w_shamt != '0);

    // Shifts by zero finish in one cycle, so the shift ops pass rs1 through here.
    always_comb begin
        w_alu_res = '0;
        case (w_op)
            c_add, c_addi:   w_alu_res = rs1_data + w_b;
            c_sub:           w_alu_res = rs1_data - w_b;
            c_or, c_ori:     w_alu_res = rs1_data | w_b;
            c_xor, c_xori:   w_alu_res = rs1_data ^ w_b;
            c_and, c_andi:   w_alu_res = rs1_data & w_b;
            c_slt, c_slti:   w_alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(w_b))};
            c_sltu, c_sltiu: w_alu_res = {{(XLEN-1){1'b0}}, (rs1_data < w_b)};
            c_sll, c_slli, c_srl, c_srli, c_sra, c_srai: w_alu_res = rs1_data;
            default:         w_alu_res = '0;
        endcase
    end

    assign w_step    = (r_rem < c_step) ? r_rem : c_step;
    assign w_rem_nxt = r_rem - w_step;
    // Kept as its own signed net so the ternary below cannot demote it to a logical shift.
    assign w_acc_sra = $signed(r_acc) >>> w_step;
    assign w_acc_nxt = r_sh_left ? (r_acc << w_step)
                     : (r_sh_arith ? w_acc_sra : (r_acc >> w_step));

    assign w_in_ready = (r_state == c_st_idle) && (!r_out_valid || out_ready) && !rst;
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_accept && w_start_shift) w_state_nxt = c_st_shift;
            default:    if (w_rem_nxt == '0) w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_alu_op    <= 5'd0;
            r_illegal   <= 1'b0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_sh_left   <= 1'b0;
            r_sh_arith  <= 1'b0;
            r_sh_op     <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_idle) begin
                if (w_accept && w_start_shift) begin
                    r_acc       <= rs1_data;
                    r_rem       <= {1'b0, w_shamt};
                    r_sh_left   <= w_is_shl;
                    r_sh_arith  <= w_is_arith;
                    r_sh_op     <= w_op;
                    r_out_valid <= 1'b0;
                end else if (w_accept) begin
                    r_result    <= w_alu_res;
                    r_alu_op    <= w_op;
                    r_illegal   <= w_illegal;
                    r_out_valid <= 1'b1;
                end else if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end else begin
                r_acc <= w_acc_nxt;
                r_rem <= w_rem_nxt;
                if (w_rem_nxt == '0) begin
                    r_result    <= w_acc_nxt;
                    r_alu_op    <= r_sh_op;
                    r_illegal   <= 1'b0;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign alu_op    = r_alu_op;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised RV32I/RV64I integer execute stage.
- Decodes the 11-bit funct code {funct7[5], funct3, opcode}, selects operand B (rs2 or immediate), and computes the result.
- Valid/ready handshakes on both input and output; shifts run on an iterative multi-cycle shifter.
- Sits between the register-read stage and writeback; generalises the combinational ALU control decoder.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHIFT_STEP, 1, bit positions shifted per cycle by the iterative shifter; power of two, 1 to XLEN.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts an operation this cycle
- funct_code  in  11  {funct7[5], funct3[2:0], opcode[6:0]}
- rs1_data  in  XLEN  operand A
- rs2_data  in  XLEN  operand B for R-type
- imm  in  XLEN  sign-extended immediate, operand B for I-type
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  ALU result
- alu_op  out  5  decoded op code of the result, for debug and forwarding
- illegal  out  1  funct_code not supported

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state returns to IDLE; out_valid=0, result=0, alu_op=0, illegal=0.
  - in_ready=0 while rst=1.
  - rst overrides all other activity, including a shift in progress; the partial result is discarded.
- Decode, with x = don't care:
  - R-type (opcode 0110011):
    - ADD 0_000=1, OR 0_110=3, XOR 0_100=5, AND 0_111=7
    - SUB 1_000=9, SLT 0_010=10, SLTU 0_011=12
    - SLL 0_001=17, SRL 0_101=18, SRA 1_101=19
  - I-type (opcode 0010011):
    - ADDI x_000=2, ORI x_110=4, XORI x_100=6, ANDI x_111=8
    - SLTI x_010=11, SLTIU x_011=13
    - SLLI 0_001=14, SRLI 0_101=15, SRAI 1_101=16
  - Anything else is illegal: alu_op=0, illegal=1, result=0. This includes other opcodes, R-type funct7[5]=1 with funct3 other than 000/101, and SLLI with bit10=1.
- Operand B = rs2_data for opcode 0110011, imm otherwise.
- Shift amount = B[SHW-1:0]. SRA/SRAI replicate rs1[XLEN-1]. SLT/SLTI compare signed; SLTU/SLTIU compare unsigned; result is zero-extended 0/1. Add/sub wrap modulo 2^XLEN.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !rst.
  - An operation is accepted when in_valid && in_ready; inputs are captured that cycle.
  - result, alu_op and illegal hold stable while out_valid && !out_ready.
  - Drain and accept in the same cycle is allowed (back-to-back, full throughput for non-shift ops).
- Latency (acceptance in cycle N):
  - Non-shift, illegal, or shift with shamt=0: out_valid=1 in cycle N+1.
  - Shift with shamt>0: out_valid=1 in cycle N+1+ceil(shamt/SHIFT_STEP).
- FSM:
  - IDLE: on accept of a shift with shamt>0, go to SHIFT. Load the accumulator with rs1 and the remaining count with shamt; out_valid drops if it is being drained.
  - SHIFT: each cycle shift by min(SHIFT_STEP, remaining) and decrement remaining by the same amount. When remaining reaches 0, register the result, assert out_valid and return to IDLE. in_ready=0 throughout.
  - Non-shift ops are never in SHIFT; they register the result directly from IDLE.
- out_valid clears on (out_valid && out_ready) unless a new result is loaded in the same cycle.

Test Plan:
- ADD, funct_code 0_000_0110011, rs1=5, rs2=7, out_ready=1 -> cycle N+1: result=12, alu_op=1, illegal=0; in_ready stays 1.
- SUB 1_000_0110011, rs1=3, rs2=5 -> result=0xFFFFFFFE, alu_op=9. SLT vs SLTU with rs1=0xFFFFFFFF, rs2=1 -> SLT result=1, SLTU result=0.
- SRAI 1_101_0010011, rs1=0x80000000, imm=31, SHIFT_STEP=1 -> in_ready=0 for cycles N+1..N+31; cycle N+32: result=0xFFFFFFFF, alu_op=16. Repeat with SHIFT_STEP=4 -> out_valid at N+9.
- Backpressure: ADDI (imm=1, rs1=9) with out_ready=0 for 3 cycles -> result=10 held stable and in_ready=0; then out_ready=1 with a new in_valid the same cycle -> both handshakes complete, next result in the following cycle.
- Illegal 1_111_0110011 and ANDI-with-R-opcode corner cases -> illegal=1, alu_op=0, result=0, 1-cycle latency. ANDI x_111_0010011 -> alu_op=8.
- rst=1 during the 10th cycle of a 31-cycle SLL -> next cycle out_valid=0, result=0, in_ready=1 after rst drops; a following ADD completes normally.
